fir_interp: RTL and testbench



---
 rtl/fir_interp_pkg.sv | 39 +++
 rtl/fir_interp_mac.sv | 61 ++++++
 rtl/fir_interp.sv | 135 +++++++++++++
 tb/tb_fir_interp.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared types, constants and fixed-point helpers for the polyphase interpolating FIR.
// Saturation of the dequantized output is enabled by defining FIR_INTERP_SAT_EN.
package fir_interp_pkg;

    localparam int DATA_SIZE = 32;
    localparam int BITS      = 10;

    typedef logic signed [DATA_SIZE-1:0] sample_t;
    typedef sample_t coeff_arr_t [32];

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE
    } state_t;

    localparam coeff_arr_t AUDIO_LMR_COEFFS = '{
        32'shfffffffd, 32'shfffffffa, 32'shfffffff4, 32'shffffffed,
        32'shffffffe5, 32'shffffffdf, 32'shffffffe2, 32'shfffffff3,
        32'sh00000015, 32'sh0000004e, 32'sh0000009b, 32'sh000000f9,
        32'sh0000015d, 32'sh000001be, 32'sh0000020e, 32'sh00000243,
        32'sh00000243, 32'sh0000020e, 32'sh000001be, 32'sh0000015d,
        32'sh000000f9, 32'sh0000009b, 32'sh0000004e, 32'sh00000015,
        32'shfffffff3, 32'shffffffe2, 32'shffffffdf, 32'shffffffe5,
        32'shffffffed, 32'shfffffff4, 32'shfffffffa, 32'shfffffffd
    };

    function automatic sample_t QUANTIZE(input sample_t v);
        return sample_t'(v <<< BITS);
    endfunction

    // Division by 2^BITS rounding toward zero: negative values are biased before the shift.
    function automatic logic signed [2*DATA_SIZE-1:0] DEQUANTIZE(input logic signed [2*DATA_SIZE-1:0] v);
        logic signed [2*DATA_SIZE-1:0] bias;
        bias = v[2*DATA_SIZE-1] ? {{(2*DATA_SIZE-BITS){1'b0}}, {BITS{1'b1}}} : '0;
        return (v + bias) >>> BITS;
    endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// Multiply-accumulate datapath with clear/enable and dequantize; the output is wrapped,
// or saturated when FIR_INTERP_SAT_EN is defined.
module fir_interp_mac
    import fir_interp_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        enable,
    input  logic signed [DATA_SIZE-1:0] a,
    input  logic signed [DATA_SIZE-1:0] b,
    output logic        [DATA_SIZE-1:0] y
);

    localparam int ACC_W = 2 * DATA_SIZE;

    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        product = ACC_W'(a) * ACC_W'(b);
        acc_d   = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + product;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef FIR_INTERP_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [ACC_W-1:0] deq;

    always_comb begin
        deq = DEQUANTIZE(acc_q);
        if (deq > SAT_MAX) begin
            y = SAT_MAX[DATA_SIZE-1:0];
        end else if (deq < SAT_MIN) begin
            y = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            y = deq[DATA_SIZE-1:0];
        end
    end
`else
    assign y = DATA_SIZE'(DEQUANTIZE(acc_q));
`endif

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR core: pops one sample upstream, pushes INTERP filtered samples
// downstream. Define FIR_INTERP_SAT_EN to saturate rather than wrap the output.
module fir_interp
    import fir_interp_pkg::*;
#(
    parameter int NUM_TAPS = 32,
    parameter int INTERP   = 8,
    parameter logic signed [DATA_SIZE-1:0] COEFFICIENTS [NUM_TAPS] = AUDIO_LMR_COEFFS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        x_in_empty,
    output logic                        x_in_rd_en,
    input  logic signed [DATA_SIZE-1:0] x_in_dout,
    input  logic                        y_out_full,
    output logic                        y_out_wr_en,
    output logic        [DATA_SIZE-1:0] y_out_din
);

    localparam int TPP   = NUM_TAPS / INTERP;
    localparam int P_W   = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int K_W   = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [P_W-1:0] P_LAST = P_W'(INTERP - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(TPP - 1);

    state_t                        state_q, state_d;
    logic [P_W-1:0]                p_q, p_d;
    logic [K_W-1:0]                k_q, k_d;
    logic signed [DATA_SIZE-1:0]   hist_q [TPP];
    logic signed [DATA_SIZE-1:0]   hist_d [TPP];
    logic                          x_in_rd_en_q, x_in_rd_en_d;
    logic                          y_out_wr_en_q, y_out_wr_en_d;
    logic [DATA_SIZE-1:0]          y_out_din_q, y_out_din_d;

    logic                          mac_clear;
    logic                          mac_en;
    logic [TAP_W-1:0]              tap_idx;
    logic [DATA_SIZE-1:0]          mac_y;

    // Phase p uses every INTERP-th coefficient starting at p.
    assign tap_idx = TAP_W'(k_q) * TAP_W'(INTERP) + TAP_W'(p_q);

    fir_interp_mac u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (hist_q[k_q]),
        .b      (COEFFICIENTS[tap_idx]),
        .y      (mac_y)
    );

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        k_d           = k_q;
        hist_d        = hist_q;
        x_in_rd_en_d  = 1'b0;
        y_out_wr_en_d = 1'b0;
        y_out_din_d   = y_out_din_q;
        mac_clear     = 1'b0;
        mac_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!x_in_empty) begin
                    x_in_rd_en_d = 1'b1;
                    for (int i = TPP - 1; i > 0; i--) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    hist_d[0] = x_in_dout;
                    p_d       = '0;
                    k_d       = '0;
                    mac_clear = 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WRITE: begin
                // A full downstream FIFO freezes acc and p here until space appears.
                if (!y_out_full) begin
                    y_out_wr_en_d = 1'b1;
                    y_out_din_d   = mac_y;
                    mac_clear     = 1'b1;
                    if (p_q == P_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        p_d     = p_q + P_W'(1);
                        state_d = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the history is only TPP words, and start-up filtering relies on it being zero,
    // so it is reset like any other register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            p_q           <= '0;
            k_q           <= '0;
            hist_q        <= '{default: '0};
            x_in_rd_en_q  <= 1'b0;
            y_out_wr_en_q <= 1'b0;
            y_out_din_q   <= '0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            k_q           <= k_d;
            hist_q        <= hist_d;
            x_in_rd_en_q  <= x_in_rd_en_d;
            y_out_wr_en_q <= y_out_wr_en_d;
            y_out_din_q   <= y_out_din_d;
        end
    end

    assign x_in_rd_en  = x_in_rd_en_q;
    assign y_out_wr_en = y_out_wr_en_q;
    assign y_out_din   = y_out_din_q;

endmodule

// File: tb/tb_fir_interp.sv
// Self-checking bench for fir_interp: three cores with different coefficient sets run in lockstep
// against a convolution model built from the sample stream.
module tb_fir_interp;
    import fir_interp_pkg::*;

    localparam int NUM_TAPS = 32;
    localparam int INTERP   = 8;
    localparam int TPP      = NUM_TAPS / INTERP;
    localparam int MAX_OUT  = 256;

    localparam coeff_arr_t C_DC  = '{default: 32'sh0000_0080};
    localparam coeff_arr_t C_OVF = '{default: 32'sh7FFF_FFFF};

    logic        clock;
    logic        reset;
    logic        x_in_empty;
    sample_t     x_in_dout;
    logic        y_out_full;
    logic        rd [3];
    logic        wr [3];
    logic [31:0] y_din [3];

    int errors;
    int checks;
    int cyc;

    sample_t     in_q [$];
    sample_t     sent [$];
    logic [31:0] outs [3][MAX_OUT];
    int          n_out [3];
    int          wr_cyc [MAX_OUT];

    int stall_cnt;
    int starve_cnt;
    int starve_gap;
    int bp_at;
    bit rand_bp;
    bit rand_starve;

    fir_interp #(.NUM_TAPS(NUM_TAPS), .INTERP(INTERP), .COEFFICIENTS(AUDIO_LMR_COEFFS)) u_lmr (
        .clock(clock), .reset(reset), .x_in_empty(x_in_empty), .x_in_rd_en(rd[0]),
        .x_in_dout(x_in_dout), .y_out_full(y_out_full), .y_out_wr_en(wr[0]), .y_out_din(y_din[0])
    );
    fir_interp #(.NUM_TAPS(NUM_TAPS), .INTERP(INTERP), .COEFFICIENTS(C_DC)) u_dc (
        .clock(clock), .reset(reset), .x_in_empty(x_in_empty), .x_in_rd_en(rd[1]),
        .x_in_dout(x_in_dout), .y_out_full(y_out_full), .y_out_wr_en(wr[1]), .y_out_din(y_din[1])
    );
    fir_interp #(.NUM_TAPS(NUM_TAPS), .INTERP(INTERP), .COEFFICIENTS(C_OVF)) u_ovf (
        .clock(clock), .reset(reset), .x_in_empty(x_in_empty), .x_in_rd_en(rd[2]),
        .x_in_dout(x_in_dout), .y_out_full(y_out_full), .y_out_wr_en(wr[2]), .y_out_din(y_din[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic sample_t coef(input int inst, input int t);
        case (inst)
            0:       return AUDIO_LMR_COEFFS[t];
            1:       return C_DC[t];
            default: return C_OVF[t];
        endcase
    endfunction

    // Output n belongs to input n/INTERP, phase n%INTERP; y = sum_k x[m-k] * h[p + k*INTERP].
    function automatic sample_t exp_y(input int inst, input int n);
        longint acc;
        longint q;
        int     m;
        int     ph;
        acc = 0;
        m   = n / INTERP;
        ph  = n % INTERP;
        for (int k = 0; k < TPP; k++) begin
            if (m - k >= 0 && m - k < sent.size())
                acc += longint'(sent[m-k]) * longint'(coef(inst, ph + k * INTERP));
        end
        q = acc / (longint'(1) <<< BITS);
`ifdef FIR_INTERP_SAT_EN
        if (q > 64'sd2147483647) return 32'sh7FFFFFFF;
        if (q < -64'sd2147483648) return 32'sh80000000;
`endif
        return sample_t'(q);
    endfunction

    task automatic drive_inputs();
        y_out_full = (stall_cnt > 0) || (rand_bp && $urandom_range(0, 3) == 0);
        x_in_empty = (in_q.size() == 0) || (starve_cnt > 0) || (rand_starve && $urandom_range(0, 3) == 0);
        x_in_dout  = (in_q.size() != 0) ? in_q[0] : 32'shDEADBEEF;
    endtask

    task automatic tick();
        logic full_b;
        logic empty_b;
        full_b  = y_out_full;
        empty_b = x_in_empty;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (rd[i] !== rd[0] || wr[i] !== wr[0]) begin
                errors++;
                $display("FAIL lockstep inst%0d: rd=%b wr=%b required rd=%b wr=%b", i, rd[i], wr[i], rd[0], wr[0]);
            end
        end
        checks++;
        if (rd[0] === 1'b1 && empty_b) begin
            errors++;
            $display("FAIL rd_while_empty at cycle %0d: rd=1 required 0", cyc);
        end
        checks++;
        if (wr[0] === 1'b1 && full_b) begin
            errors++;
            $display("FAIL wr_while_full at cycle %0d: wr=1 required 0", cyc);
        end
        if (rd[0] === 1'b1 && in_q.size() != 0) sent.push_back(in_q.pop_front());
        if (wr[0] === 1'b1 && n_out[0] < MAX_OUT) begin
            wr_cyc[n_out[0]] = cyc;
            for (int i = 0; i < 3; i++) begin
                outs[i][n_out[i]] = y_din[i];
                n_out[i]++;
            end
            if (starve_gap > 0 && n_out[0] % INTERP == 0) starve_cnt = starve_gap + 1;
        end
        if (stall_cnt > 0) stall_cnt--;
        if (starve_cnt > 0) starve_cnt--;
        if (bp_at >= 0 && n_out[0] == bp_at) begin
            stall_cnt = 20;
            bp_at     = -1;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        x_in_empty  = 1'b1;
        x_in_dout   = '0;
        y_out_full  = 1'b0;
        stall_cnt   = 0;
        starve_cnt  = 0;
        starve_gap  = 0;
        bp_at       = -1;
        rand_bp     = 1'b0;
        rand_starve = 1'b0;
        in_q.delete();
        sent.delete();
        for (int i = 0; i < 3; i++) n_out[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int start;
        start = cyc;
        drive_inputs();
        while (n_out[0] < target && (cyc - start) < budget) tick();
        checks++;
        if (n_out[0] < target) begin
            errors++;
            $display("FAIL %s timeout: outputs=%0d required=%0d", tag, n_out[0], target);
        end
        repeat (60) tick();
        checks++;
        if (n_out[0] != target) begin
            errors++;
            $display("FAIL %s output count: got %0d required %0d", tag, n_out[0], target);
        end
    endtask

    task automatic push_impulse();
        in_q.push_back(32'sh0000_0400);
        repeat (3) in_q.push_back('0);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        x_in_empty = 1'b1;
        x_in_dout  = '0;
        y_out_full = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i] !== 1'b0 || wr[i] !== 1'b0 || y_din[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_values inst%0d: rd=%b wr=%b din=%h required 0 0 00000000", i, rd[i], wr[i], y_din[i]);
            end
        end
    endtask

    task automatic test_impulse();
        do_reset();
        push_impulse();
        run_until(32, 1000, "impulse");
        for (int n = 0; n < 32 && n < n_out[0]; n++) begin
            checks++;
            if (outs[0][n] !== AUDIO_LMR_COEFFS[n]) begin
                errors++;
                $display("FAIL impulse y[%0d]: got %h required %h", n, outs[0][n], AUDIO_LMR_COEFFS[n]);
            end
        end
    endtask

    task automatic test_dc();
        int g;
        logic [31:0] want;
        do_reset();
        repeat (6) in_q.push_back(32'sh0000_0400);
        run_until(48, 1000, "dc");
        for (int n = 0; n < n_out[1]; n++) begin
            g    = n / INTERP + 1;
            want = 32'(128 * ((g > TPP) ? TPP : g));
            checks++;
            if (outs[1][n] !== want) begin
                errors++;
                $display("FAIL dc y[%0d]: got %h required %h", n, outs[1][n], want);
            end
        end
    endtask

    task automatic test_random();
        sample_t s;
        do_reset();
        rand_bp     = 1'b1;
        rand_starve = 1'b1;
        for (int j = 0; j < 12; j++) begin
            case ($urandom_range(0, 2))
                0:       s = sample_t'($urandom());
                1:       s = sample_t'($urandom_range(0, 8191)) - 32'sd4096;
                default: s = -sample_t'($urandom_range(1, 32'h00FF_FFFF));
            endcase
            in_q.push_back(s);
        end
        run_until(12 * INTERP, 4000, "random");
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < n_out[i]; n++) begin
                checks++;
                if (outs[i][n] !== exp_y(i, n)) begin
                    errors++;
                    $display("FAIL random inst%0d y[%0d]: got %h required %h", i, n, outs[i][n], exp_y(i, n));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int j = 0; j < 5; j++) in_q.push_back(sample_t'($urandom_range(0, 65535)) - 32'sd32768);
        bp_at = INTERP + 3;
        run_until(5 * INTERP, 2000, "backpressure");
        checks++;
        if (wr_cyc[INTERP + 3] - wr_cyc[INTERP + 2] < 20) begin
            errors++;
            $display("FAIL backpressure stall gap: got %0d cycles required >= 20", wr_cyc[INTERP + 3] - wr_cyc[INTERP + 2]);
        end
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < n_out[i]; n++) begin
                checks++;
                if (outs[i][n] !== exp_y(i, n)) begin
                    errors++;
                    $display("FAIL backpressure inst%0d y[%0d]: got %h required %h", i, n, outs[i][n], exp_y(i, n));
                end
            end
        end
    endtask

    task automatic test_starvation();
        int gap;
        do_reset();
        starve_gap = 50;
        for (int j = 0; j < 4; j++) in_q.push_back(sample_t'($urandom()));
        run_until(4 * INTERP, 2000, "starvation");
        for (int n = 1; n < n_out[0]; n++) begin
            gap = wr_cyc[n] - wr_cyc[n-1];
            checks++;
            if (n % INTERP != 0 && gap != TPP + 1) begin
                errors++;
                $display("FAIL starvation intra-group gap y[%0d]: got %0d required %0d", n, gap, TPP + 1);
            end else if (n % INTERP == 0 && gap < 50) begin
                errors++;
                $display("FAIL starvation inter-group gap y[%0d]: got %0d required >= 50", n, gap);
            end
        end
        for (int n = 0; n < n_out[0]; n++) begin
            checks++;
            if (outs[0][n] !== exp_y(0, n)) begin
                errors++;
                $display("FAIL starvation y[%0d]: got %h required %h", n, outs[0][n], exp_y(0, n));
            end
        end
    endtask

    task automatic test_reset_mid();
        int start;
        do_reset();
        push_impulse();
        drive_inputs();
        start = cyc;
        while (n_out[0] < 3 && (cyc - start) < 500) tick();
        checks++;
        if (n_out[0] != 3) begin
            errors++;
            $display("FAIL reset_mid pre-reset outputs: got %0d required 3", n_out[0]);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i] !== 1'b0 || wr[i] !== 1'b0 || y_din[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid outputs inst%0d: rd=%b wr=%b din=%h required 0 0 00000000", i, rd[i], wr[i], y_din[i]);
            end
        end
        do_reset();
        push_impulse();
        run_until(32, 1000, "reset_mid");
        for (int n = 0; n < n_out[0]; n++) begin
            checks++;
            if (outs[0][n] !== AUDIO_LMR_COEFFS[n]) begin
                errors++;
                $display("FAIL reset_mid impulse y[%0d]: got %h required %h", n, outs[0][n], AUDIO_LMR_COEFFS[n]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] want;
`ifdef FIR_INTERP_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'hFFC0_0000;
`endif
        do_reset();
        in_q.push_back(32'sh7FFF_FFFF);
        repeat (3) in_q.push_back('0);
        run_until(32, 1000, "overflow");
        for (int n = 0; n < n_out[2]; n++) begin
            checks++;
            if (outs[2][n] !== want) begin
                errors++;
                $display("FAIL overflow y[%0d]: got %h required %h", n, outs[2][n], want);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        test_reset();
        test_impulse();
        test_dc();
        test_random();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
